// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - funct3 encodings and access legality/byte-enable helpers
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Load legality; invalid load encodings report as not aligned.
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B, F3_BU: is_aligned = 1'b1;
      F3_H, F3_HU: is_aligned = ~offset[0];
      F3_W:        is_aligned = (offset == 2'b00);
      default:     is_aligned = 1'b0;
    endcase
  endfunction

  // All-zero enable means the store is illegal and must be suppressed.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B:    store_be = 4'b0001 << offset;
      F3_H:    store_be = offset[0] ? 4'b0000 : (4'b0011 << offset);
      F3_W:    store_be = (offset == 2'b00) ? 4'b1111 : 4'b0000;
      default: store_be = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - byte/halfword extraction with sign/zero extension
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  assign sel_b = word[8*offset +: 8];
  assign sel_h = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = '0;
    if (is_aligned(funct3, offset)) begin
      case (funct3)
        F3_B:    data = {{24{sel_b[7]}}, sel_b};
        F3_BU:   data = {24'b0, sel_b};
        F3_H:    data = {{16{sel_h[15]}}, sel_h};
        F3_HU:   data = {16'b0, sel_h};
        F3_W:    data = word;
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressable RV32I data memory with debug counters
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      WriteData,
  input  logic [2:0]       funct3,
  output logic [31:0]      ReadData,
  output logic             MisalignErr,
  output logic [CNT_W-1:0] LoadCount,
  output logic [CNT_W-1:0] StoreCount
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic          load_ok;
  logic          do_store;
  logic          do_load;
  logic          access_err;

  assign idx = ALUResult[AW+1:2];
  assign off = ALUResult[1:0];
  assign be  = store_be(funct3, off);

  assign load_ok    = is_aligned(funct3, off);
  assign do_store   = MemWrite && (be != 4'b0000);
  assign do_load    = MemRead && !MemWrite && load_ok;
  // A combined read+write is judged purely as a store.
  assign access_err = MemWrite ? (be == 4'b0000) : (MemRead && !load_ok);

  always_comb begin
    wlanes = WriteData;
    case (funct3)
      F3_B:    wlanes = {4{WriteData[7:0]}};
      F3_H:    wlanes = {2{WriteData[15:0]}};
      default: wlanes = WriteData;
    endcase
  end

  dmem_load_align u_load_align (
    .word   (mem[idx]),
    .offset (off),
    .funct3 (funct3),
    .data   (ReadData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MisalignErr <= 1'b0;
      LoadCount   <= '0;
      StoreCount  <= '0;
    end else begin
      if (access_err) MisalignErr <= 1'b1;
      if (do_load && (LoadCount != {CNT_W{1'b1}})) LoadCount <= LoadCount + 1'b1;
      if (do_store && (StoreCount != {CNT_W{1'b1}})) StoreCount <= StoreCount + 1'b1;
    end
  end

endmodule
